// File: rtl/jdquant_share_pkg.sv
// Shared types and defaults for the dequantizer page-sharing scheduler.
package jdquant_share_pkg;
    localparam int WIDTH_DEF     = 16;
    localparam int BLOCK_LEN_DEF = 64;
    localparam int TAG_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN0 = 2'd1,
        RUN1 = 2'd2
    } schedStateT;

    typedef logic tagT;
endpackage

// File: rtl/jdquant_share_if.sv
// Token stream: data, end-of-stream flag, valid, and back-pressure (1 = stall).
interface jdquant_share_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] d;
    logic             e;
    logic             v;
    logic             b;

    modport master (output d, e, v, input b);
    modport slave  (input d, e, v, output b);
endinterface

// File: rtl/jdquant_share_tagq.sv
// In-order FIFO of block owner tags; push and pop may coincide.
module jdquant_share_tagq
    import jdquant_share_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  tagT  pushTag,
    input  logic pop,
    output tagT  headTag,
    output logic full,
    output logic empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    tagT           mem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count;
    logic          doPush, doPop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign headTag = mem[rdPtr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop)  rdPtr <= nextPtr(rdPtr);
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushTag;
    end
endmodule

// File: rtl/jdquant_share_sched.sv
// Block-granular round-robin sharing of one dequantizer page between two
// coefficient streams; page results are steered back by an in-order tag queue.
module jdquant_share_sched
    import jdquant_share_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int BLOCK_LEN = BLOCK_LEN_DEF,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    jdquant_share_if.slave  in0,
    jdquant_share_if.slave  in1,
    jdquant_share_if.master pgIn,
    jdquant_share_if.slave  pgOut,
    jdquant_share_if.master out0,
    jdquant_share_if.master out1,
    output logic            err
);
    localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int PW = $clog2(TAG_DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(BLOCK_LEN - 1);

    schedStateT            state, stateNxt;
    logic                  prefer1, prefer1Nxt;
    logic [CW-1:0]         inCnt, inCntNxt, outCnt, outCntNxt;
    logic [1:0]            done, doneSet, eosSent, eosSet;
    logic [1:0][PW-1:0]    pend;
    logic                  errIn, errOut;
    logic                  push, pop, qFull, qEmpty;
    tagT                   pushTag, headTag, runTag;
    logic [1:0]            inV, inE, inB, elig, outV, outE, outB;
    logic [1:0][WIDTH-1:0] inD, outD;

    assign inV  = {in1.v, in0.v};
    assign inE  = {in1.e, in0.e};
    assign inD  = {in1.d, in0.d};
    assign outB = {out1.b, out0.b};

    assign in0.b  = inB[0];
    assign in1.b  = inB[1];
    assign out0.v = outV[0];
    assign out0.e = outE[0];
    assign out0.d = outD[0];
    assign out1.v = outV[1];
    assign out1.e = outE[1];
    assign out1.d = outD[1];

    assign elig   = inV & ~inE & ~done;
    assign runTag = (state == RUN1);

    jdquant_share_tagq #(.DEPTH(TAG_DEPTH)) tagQ (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pushTag(pushTag),
        .pop    (pop),
        .headTag(headTag),
        .full   (qFull),
        .empty  (qEmpty)
    );

    // Input side: grant a whole block, then pass it through to the page.
    always_comb begin : inputSide
        stateNxt   = state;
        prefer1Nxt = prefer1;
        inCntNxt   = inCnt;
        doneSet    = '0;
        errIn      = 1'b0;
        push       = 1'b0;
        pushTag    = 1'b0;
        inB        = 2'b11;
        pgIn.d     = '0;
        pgIn.e     = 1'b0;
        pgIn.v     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    for (int k = 0; k < 2; k++) begin
                        if (inV[k] && inE[k] && !done[k]) begin
                            inB[k]     = 1'b0;
                            doneSet[k] = 1'b1;
                        end
                    end
                    if (!qFull && elig != 2'b00) begin
                        push       = 1'b1;
                        pushTag    = (elig == 2'b11) ? prefer1 : elig[1];
                        prefer1Nxt = !pushTag;
                        stateNxt   = pushTag ? RUN1 : RUN0;
                    end
                end
                RUN0, RUN1: begin
                    pgIn.d      = inD[runTag];
                    pgIn.v      = inV[runTag] && !inE[runTag];
                    inB[runTag] = inE[runTag] ? 1'b0 : pgIn.b;
                    if (inV[runTag] && inE[runTag]) begin
                        // Truncated block: its tag stays queued, the page stream is now unusable.
                        errIn           = 1'b1;
                        doneSet[runTag] = 1'b1;
                        stateNxt        = IDLE;
                        inCntNxt        = '0;
                    end else if (inV[runTag] && !pgIn.b) begin
                        if (inCnt == LAST) begin
                            stateNxt = IDLE;
                            inCntNxt = '0;
                        end else begin
                            inCntNxt = inCnt + 1'b1;
                        end
                    end
                end
                default: stateNxt = IDLE;
            endcase
        end
    end

    // Output side: head tag owns the page output; idle done ports emit their EOS.
    always_comb begin : outputSide
        outV      = '0;
        outE      = '0;
        outD      = '0;
        pgOut.b   = 1'b1;
        pop       = 1'b0;
        outCntNxt = outCnt;
        errOut    = 1'b0;
        eosSet    = '0;
        if (!rst) begin
            if (!qEmpty) begin
                outD[headTag] = pgOut.d;
                outV[headTag] = pgOut.v && !pgOut.e;
                pgOut.b       = pgOut.e ? 1'b0 : outB[headTag];
                if (pgOut.v && pgOut.e) begin
                    errOut = 1'b1;
                end else if (pgOut.v && !outB[headTag]) begin
                    if (outCnt == LAST) begin
                        pop       = 1'b1;
                        outCntNxt = '0;
                    end else begin
                        outCntNxt = outCnt + 1'b1;
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (done[k] && pend[k] == '0 && !eosSent[k] &&
                    !(!qEmpty && headTag == k[0])) begin
                    outV[k]   = 1'b1;
                    outE[k]   = 1'b1;
                    outD[k]   = '0;
                    eosSet[k] = !outB[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            prefer1 <= 1'b0;
            inCnt   <= '0;
            outCnt  <= '0;
            done    <= '0;
            eosSent <= '0;
            pend    <= '0;
            err     <= 1'b0;
        end else begin
            state   <= stateNxt;
            prefer1 <= prefer1Nxt;
            inCnt   <= inCntNxt;
            outCnt  <= outCntNxt;
            done    <= done | doneSet;
            eosSent <= eosSent | eosSet;
            err     <= err | errIn | errOut;
            for (int k = 0; k < 2; k++) begin
                if ((push && pushTag == k[0]) && !(pop && headTag == k[0]))
                    pend[k] <= pend[k] + 1'b1;
                else if (!(push && pushTag == k[0]) && (pop && headTag == k[0]))
                    pend[k] <= pend[k] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jdquant_share_sched.sv
// Directed bench: echo-page model, per-requester expected streams, literal spot checks.
module tb_jdquant_share_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;

    jdquant_share_if #(.WIDTH(16)) in0If ();
    jdquant_share_if #(.WIDTH(16)) in1If ();
    jdquant_share_if #(.WIDTH(16)) pgInIf ();
    jdquant_share_if #(.WIDTH(16)) pgOutIf ();
    jdquant_share_if #(.WIDTH(16)) out0If ();
    jdquant_share_if #(.WIDTH(16)) out1If ();

    jdquant_share_sched #(.WIDTH(16), .BLOCK_LEN(64), .TAG_DEPTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .in0  (in0If),
        .in1  (in1If),
        .pgIn (pgInIf),
        .pgOut(pgOutIf),
        .out0 (out0If),
        .out1 (out1If),
        .err  (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [16:0] in0Q[$], in1Q[$], exp0Q[$], exp1Q[$];
    logic [15:0] pageQ[$], pgInLog[$];
    int pgInCount = 0;
    bit pageHold = 1'b0;
    bit randStall = 1'b0;
    bit out0Hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] mk(input logic e, input int val);
        return {e, val[15:0]};
    endfunction

    task automatic addStream(input int who, input int base, input int n, input bit withExp);
        for (int i = 0; i < n; i++) begin
            if (who == 0) begin
                in0Q.push_back(mk(1'b0, base + i));
                if (withExp) exp0Q.push_back(mk(1'b0, base + i));
            end else begin
                in1Q.push_back(mk(1'b0, base + i));
                if (withExp) exp1Q.push_back(mk(1'b0, base + i));
            end
        end
    endtask

    task automatic drain(input string name, input int maxCyc);
        int n = 0;
        while ((in0Q.size() != 0 || in1Q.size() != 0 || pageQ.size() != 0 ||
                exp0Q.size() != 0 || exp1Q.size() != 0) && n < maxCyc) begin
            @(negedge clk); #2;
            n++;
        end
        check(name, 32'(n < maxCyc), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // Environment: stream drivers, echoing page, and output scoreboard.
    initial begin : engine
        logic x0, x1, xpi, xpo, xo0, xo1;
        logic [15:0] pgInD;
        logic [16:0] tok;
        in0If.v = 0; in0If.e = 0; in0If.d = '0;
        in1If.v = 0; in1If.e = 0; in1If.d = '0;
        pgInIf.b = 0;
        pgOutIf.v = 0; pgOutIf.e = 0; pgOutIf.d = '0;
        out0If.b = 0; out1If.b = 0;
        forever begin
            @(negedge clk);
            x0    = in0If.v & ~in0If.b;
            x1    = in1If.v & ~in1If.b;
            xpi   = pgInIf.v & ~pgInIf.b;
            xpo   = pgOutIf.v & ~pgOutIf.b;
            xo0   = out0If.v & ~out0If.b;
            xo1   = out1If.v & ~out1If.b;
            pgInD = pgInIf.d;
            if (xpi && pgInIf.e) check("pgIn e", 32'(pgInIf.e), 32'd0);
            if (xo0) begin
                if (exp0Q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out0 unexpected token: got %0h expected none", {out0If.e, out0If.d});
                end else begin
                    tok = exp0Q.pop_front();
                    check("out0 token", 32'({out0If.e, out0If.d}), 32'(tok));
                end
            end
            if (xo1) begin
                if (exp1Q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out1 unexpected token: got %0h expected none", {out1If.e, out1If.d});
                end else begin
                    tok = exp1Q.pop_front();
                    check("out1 token", 32'({out1If.e, out1If.d}), 32'(tok));
                end
            end
            @(posedge clk); #1;
            if (x0 && in0Q.size() != 0) void'(in0Q.pop_front());
            if (x1 && in1Q.size() != 0) void'(in1Q.pop_front());
            if (xpi) begin
                pageQ.push_back(pgInD);
                pgInLog.push_back(pgInD);
                pgInCount++;
            end
            if (xpo && pageQ.size() != 0) void'(pageQ.pop_front());
            in0If.v = (in0Q.size() != 0);
            in0If.d = (in0Q.size() != 0) ? in0Q[0][15:0] : 16'h0;
            in0If.e = (in0Q.size() != 0) ? in0Q[0][16] : 1'b0;
            in1If.v = (in1Q.size() != 0);
            in1If.d = (in1Q.size() != 0) ? in1Q[0][15:0] : 16'h0;
            in1If.e = (in1Q.size() != 0) ? in1Q[0][16] : 1'b0;
            pgInIf.b  = (pageQ.size() >= 512) || (randStall && $urandom_range(3) == 0);
            pgOutIf.v = !pageHold && pageQ.size() != 0;
            pgOutIf.d = (pageQ.size() != 0) ? pageQ[0] : 16'h0;
            pgOutIf.e = 1'b0;
            out0If.b  = out0Hold || (randStall && $urandom_range(3) == 0);
            out1If.b  = randStall && $urandom_range(3) == 0;
        end
    end

    initial begin : main
        // Reset with both requesters already offering two blocks each.
        addStream(0, 16'h0100, 128, 1'b1);
        addStream(1, 16'h8100, 128, 1'b1);
        idle(3);
        check("rst in0_b", 32'(in0If.b), 32'd1);
        check("rst in1_b", 32'(in1If.b), 32'd1);
        check("rst pg_out_b", 32'(pgOutIf.b), 32'd1);
        check("rst pg_in_v", 32'(pgInIf.v), 32'd0);
        check("rst out0_v", 32'(out0If.v), 32'd0);
        check("rst out1_v", 32'(out1If.v), 32'd0);
        check("rst err", 32'(err), 32'd0);
        randStall = 1'b1;
        rst = 1'b0;
        drain("both drain", 3000);
        randStall = 1'b0;
        check("both pg_in count", pgInCount, 256);
        if (pgInLog.size() >= 256) begin
            check("grant order", 32'({pgInLog[0][15], pgInLog[64][15], pgInLog[128][15], pgInLog[192][15]}), 32'b0101);
            check("first block head", 32'(pgInLog[0]), 32'h0100);
            check("second block head", 32'(pgInLog[64]), 32'h8100);
        end

        // Single requester, tokens 0..63.
        pgInLog.delete(); pgInCount = 0;
        addStream(0, 0, 64, 1'b1);
        drain("single drain", 500);
        check("single pg_in count", pgInCount, 64);
        if (pgInLog.size() == 64) check("single last token", 32'(pgInLog[63]), 32'd63);

        // Page output held: only TAG_DEPTH blocks may be granted.
        pageHold = 1'b1; pgInCount = 0;
        addStream(0, 16'h1000, 192, 1'b1);
        addStream(1, 16'h9000, 128, 1'b1);
        idle(600);
        check("held grant tokens", pgInCount, 256);
        check("held in0_b", 32'(in0If.b), 32'd1);
        check("held in1_b", 32'(in1If.b), 32'd1);
        pageHold = 1'b0;
        drain("held drain", 3000);
        check("held total tokens", pgInCount, 320);

        // Asynchronous reset while a block sits at the output.
        out0Hold = 1'b1;
        addStream(0, 16'h2000, 64, 1'b0);
        idle(150);
        check("pre-reset out0_v", 32'(out0If.v), 32'd1);
        @(posedge clk); #3;
        rst = 1'b1;
        in0Q.delete(); in1Q.delete(); pageQ.delete(); exp0Q.delete(); exp1Q.delete();
        pgInLog.delete(); pgInCount = 0;
        #1;
        check("async rst out0_v", 32'(out0If.v), 32'd0);
        check("async rst out0_d", 32'(out0If.d), 32'd0);
        check("async rst in0_b", 32'(in0If.b), 32'd1);
        check("async rst in1_b", 32'(in1If.b), 32'd1);
        check("async rst pg_out_b", 32'(pgOutIf.b), 32'd1);
        out0Hold = 1'b0;
        idle(2);
        rst = 1'b0;
        addStream(1, 16'hA000, 64, 1'b1);
        drain("post-reset drain", 500);
        check("post-reset pg_in count", pgInCount, 64);

        // End of stream on in1 after one block while in0 keeps going.
        addStream(1, 16'hB000, 64, 1'b1);
        in1Q.push_back(mk(1'b1, 0));
        exp1Q.push_back(mk(1'b1, 0));
        addStream(0, 16'h3000, 128, 1'b1);
        drain("eos drain", 1000);
        check("eos err", 32'(err), 32'd0);
        in1Q.push_back(mk(1'b0, 16'hBEEF));
        idle(100);
        check("eos in1 stalled", in1Q.size(), 1);
        check("eos in1_b", 32'(in1If.b), 32'd1);
        in1Q.delete();

        // Mid-block end of stream on in0 after 10 tokens.
        addStream(0, 16'h4000, 10, 1'b1);
        in0Q.push_back(mk(1'b1, 0));
        begin
            int n = 0;
            while (in0Q.size() != 0 && n < 500) begin
                @(negedge clk); #2;
                n++;
            end
            check("trunc eos consumed", 32'(n < 500), 32'd1);
        end
        check("trunc err", 32'(err), 32'd1);
        idle(20);
        check("trunc out0 delivered", exp0Q.size(), 0);
        in0Q.push_back(mk(1'b0, 16'h4444));
        idle(20);
        check("trunc in0_b", 32'(in0If.b), 32'd1);
        check("trunc pg_in_v", 32'(pgInIf.v), 32'd0);
        check("trunc in0 stalled", in0Q.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jdquant_share_sched.md
# jdquant_share_sched

Block-granular round-robin scheduler that time-shares one dequantizer page (the 16-bit JPEG decode quant stage, 1:1 token in/out) between two coefficient streams. It grants one requester for a whole 64-coefficient block, forwards that block into the shared page, and steers the page's output tokens back to the owning requester's output stream using an in-order tag queue. It sits between the per-component Huffman/run-length pages and the IDCT pages in the decode pipeline.

## Interface
- WIDTH, 16, token data width
- BLOCK_LEN, 64, tokens per block (power of two)
- TAG_DEPTH, 4, max blocks in flight inside the shared page
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in0_d / in1_d  in  WIDTH  requester input data
- in0_e / in1_e  in  1  end-of-stream flag on token
- in0_v / in1_v  in  1  token valid
- in0_b / in1_b  out  1  back-pressure (1 = stall)
- pg_in_d, pg_in_e, pg_in_v  out  WIDTH,1,1  to shared page input stream
- pg_in_b  in  1  page input back-pressure
- pg_out_d, pg_out_e, pg_out_v  in  WIDTH,1,1  from shared page output stream
- pg_out_b  out  1  page output back-pressure
- out0_d/_e/_v, out1_d/_e/_v  out  WIDTH,1,1  per-requester result streams
- out0_b / out1_b  in  1  result back-pressure
- err  out  1  sticky protocol-error flag

## Operation
- Transfer on any stream: v=1 and b=0 in same cycle.
- Input FSM: IDLE, RUN0, RUN1. IDLE: pick requester k with in_k_v=1, in_k_e=0, done_k=0; both eligible -> the one not granted last; tag queue full -> no grant. Grant pushes tag k, increments pend_k.
- RUNk: in_k routed combinationally to pg_in (e forced 0); in_k_b = pg_in_b; other in_b = 1. 6-bit in_cnt counts transfers; transfer at in_cnt = BLOCK_LEN-1 -> IDLE, in_cnt=0.
- EOS token (in_k_e=1) seen in IDLE: consumed (in_k_b=0 that cycle), not forwarded, sets done_k. Further tokens on in_k stalled until reset.
- EOS token in RUNk mid-block: consumed, dropped, err set, FSM -> IDLE, done_k set; truncated block's tag stays (page stream corrupt; err is fatal).
- Output side: head tag h of queue selects out_h; pg_out routed combinationally to out_h, pg_out_b = out_h_b; non-selected out_v = 0. out_cnt counts; at BLOCK_LEN-1 pop tag, decrement pend_h. Queue empty -> pg_out_b = 1.
- pg_out_e=1 token: consumed, dropped, err set.
- EOS emission: when done_k, pend_k = 0, eos_sent_k = 0, and out_k not currently selected -> out_k_v=1, out_k_e=1, out_k_d=0; on transfer set eos_sent_k. Output data selection has priority over EOS on the same port.
- pend_k width: clog2(TAG_DEPTH+1); push and pop same cycle on same k -> unchanged.

## Timing
- Reset values: all in_b = 1, pg_out_b = 1, all *_v = 0, *_e = 0, *_d = 0, err = 0; FSM IDLE, counters 0, queue empty, flags clear.
- Data path zero-latency (combinational pass-through); grant is registered: one bubble cycle between blocks of the input side.
- Simultaneous tag push and pop allowed, including when full (pop frees slot next cycle only; full blocks grant this cycle).
- Reset asserted mid-block: everything returns to reset state immediately; partial blocks lost.

## Structure
- Package jdquant_share_pkg: state enum (IDLE, RUN0, RUN1), WIDTH/BLOCK_LEN defaults, tag type (1 bit).
- Sub-module jdquant_share_tagq: TAG_DEPTH x 1-bit synchronous FIFO with full/empty, push/pop same cycle.

## Test plan
- in0 sends 64 tokens 0..63, page model echoes -> out0 receives 0..63 in order, out1_v never 1.
- Both inputs valid continuously, 2 blocks each -> grant order 0,1,0,1; outputs reassembled per requester with correct data.
- Page output stalled (model holds) with 5 blocks offered -> exactly 4 grants, 5th waits until first block drains.
- in1 EOS after 1 block, in0 still running -> out1 gets 64 tokens then one e=1 token; in0 unaffected.
- in0 e=1 at token 10 of a block -> err=1 next cycle, FSM IDLE, in0_b stays 1.
- Reset pulse during block output -> all *_v=0, in_b=1 asynchronously; fresh block after reset passes cleanly.
